data_rx_reg: RTL and testbench

Receive-side data register between the UART receiver and the CPU, in the CPU clock domain. It captures each completed frame (data plus error flags) on the rising edge of the receiver's rx_done. Frames are held in a small FIFO and presented to the CPU over a valid/ready handshake. If a frame arrives while the FIFO is full, the frame is dropped and a sticky overrun flag is raised.

---
 rtl/uart_pkg.sv | 14 +
 rtl/rx_done_edge.sv | 42 ++++
 rtl/data_rx_reg.sv | 117 +++++++++++
 tb/tb_data_rx_reg.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART receive-path types and constants.
// The optional RX_DONE_SYNC_EN build adds a synchronizer in rx_done_edge.
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;
  localparam int RX_SYNC_STAGES  = 2;

  typedef struct packed {
    logic [UART_DATA_WIDTH-1:0] data;
    logic                       parity_err;
    logic                       frame_err;
  } rx_entry_t;

endpackage

// File: rtl/rx_done_edge.sv
// Rising-edge detector on rx_done, one-cycle push pulse out.
// RX_DONE_SYNC_EN inserts a two-flop synchronizer (reset high) in front.
module rx_done_edge
  import uart_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic rx_done_i,
  output logic push_o
);

  logic lvl;
  logic prev_q;

`ifdef RX_DONE_SYNC_EN
  logic [RX_SYNC_STAGES-1:0] sync_q;

  // Reset high so a receiver already done at release is not a new frame.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[RX_SYNC_STAGES-2:0], rx_done_i};
    end
  end

  assign lvl = sync_q[RX_SYNC_STAGES-1];
`else
  assign lvl = rx_done_i;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= lvl;
    end
  end

  assign push_o = lvl & ~prev_q;

endmodule

// File: rtl/data_rx_reg.sv
// Receive data FIFO between UART receiver and CPU (valid/ready side).
// Build option RX_DONE_SYNC_EN: synchronize rx_done before edge detect.
module data_rx_reg
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int DEPTH      = 4
) (
  input  logic                         cpu_clk,
  input  logic                         rst,
  input  logic [DATA_WIDTH-1:0]        rx_data,
  input  logic                         rx_done,
  input  logic                         rx_parity_err,
  input  logic                         rx_frame_err,
  output logic                         cpu_valid,
  input  logic                         cpu_ready,
  output logic [DATA_WIDTH-1:0]        cpu_data,
  output logic                         cpu_parity_err,
  output logic                         cpu_frame_err,
  output logic                         overrun,
  input  logic                         overrun_clr,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  parity_err;
    logic                  frame_err;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          wr_entry;
  entry_t          head;

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overrun_q, overrun_d;

  logic            push;
  logic            pop;
  logic            full;
  logic            accept;
  logic            drop;

  rx_done_edge u_edge (
    .clk_i     (cpu_clk),
    .rst_i     (rst),
    .rx_done_i (rx_done),
    .push_o    (push)
  );

  assign wr_entry = '{
    data:       rx_data,
    parity_err: rx_parity_err,
    frame_err:  rx_frame_err
  };

  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  always_comb begin
    pop    = (count_q != '0) & cpu_ready;
    full   = (count_q == CW'(DEPTH));
    accept = push & (~full | pop);
    drop   = push & full & ~pop;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (accept) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    unique case ({accept, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    overrun_d = drop | (overrun_q & ~overrun_clr);
  end

  always_ff @(posedge cpu_clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (!rst && accept) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  assign head           = mem_q[rd_ptr_q];
  assign cpu_data       = head.data;
  assign cpu_parity_err = head.parity_err;
  assign cpu_frame_err  = head.frame_err;
  assign cpu_valid      = (count_q != '0);
  assign overrun        = overrun_q;
  assign count          = count_q;

endmodule

// File: tb/tb_data_rx_reg.sv
// Self-checking bench for data_rx_reg: vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_data_rx_reg;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);
`ifdef RX_DONE_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic          cpu_clk = 1'b0;
  logic          rst;
  logic [DW-1:0] rx_data;
  logic          rx_done;
  logic          rx_parity_err;
  logic          rx_frame_err;
  logic          cpu_valid;
  logic          cpu_ready;
  logic [DW-1:0] cpu_data;
  logic          cpu_parity_err;
  logic          cpu_frame_err;
  logic          overrun;
  logic          overrun_clr;
  logic [CW-1:0] count;

  int checks = 0;
  int errors = 0;

  data_rx_reg #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .cpu_clk        (cpu_clk),
    .rst            (rst),
    .rx_data        (rx_data),
    .rx_done        (rx_done),
    .rx_parity_err  (rx_parity_err),
    .rx_frame_err   (rx_frame_err),
    .cpu_valid      (cpu_valid),
    .cpu_ready      (cpu_ready),
    .cpu_data       (cpu_data),
    .cpu_parity_err (cpu_parity_err),
    .cpu_frame_err  (cpu_frame_err),
    .overrun        (overrun),
    .overrun_clr    (overrun_clr),
    .count          (count)
  );

  always #5 cpu_clk = ~cpu_clk;

  // Reference model: a FIFO of {data, parity, frame} plus a sticky flag.
  logic [DW+1:0] mq[$];
  bit            movr;
  bit            hist[$];
  bit            eff_prev;

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", n, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    movr     = 1'b0;
    hist     = '{1'b1, 1'b1};
    eff_prev = 1'b1;
  endtask

  // One clock: advance the model with the inputs seen at the edge,
  // then compare the DUT against it just after the edge.
  task automatic step();
    logic [DW+1:0] e;
    bit rs, rd, rdy, clr, eff, pu, po;
    int sz;
    e   = {rx_data, rx_parity_err, rx_frame_err};
    rs  = rst;
    rd  = rx_done;
    rdy = cpu_ready;
    clr = overrun_clr;
    @(posedge cpu_clk);
    if (rs) begin
      model_reset();
    end else begin
      // rx_done as seen by the edge detector, delayed LAT-1 cycles
      hist.push_back(rd);
      eff = hist[hist.size()-LAT];
      while (hist.size() > 2) void'(hist.pop_front());
      pu       = eff & ~eff_prev;
      eff_prev = eff;
      sz       = mq.size();
      po       = (sz != 0) && rdy;
      if (pu && sz == DEPTH && !po) movr = 1'b1;
      else if (clr) movr = 1'b0;
      if (po) void'(mq.pop_front());
      if (pu && (sz < DEPTH || po)) mq.push_back(e);
    end
    #1;
    chk("m_count", 32'(count), 32'(mq.size()));
    chk("m_valid", 32'(cpu_valid), 32'(mq.size() != 0));
    chk("m_overrun", 32'(overrun), 32'(movr));
    if (mq.size() != 0)
      chk("m_head", 32'({cpu_data, cpu_parity_err, cpu_frame_err}),
          32'(mq[0]));
  endtask

  typedef struct {
    bit            done;
    logic [DW-1:0] d;
    bit            pe;
    bit            fe;
    bit            rdy;
    bit            clr;
    int            c;
    bit            ovr;
    logic [DW-1:0] hd;
    bit            hpe;
    bit            hfe;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit done, logic [DW-1:0] d, bit pe, bit fe,
                              bit rdy, bit clr, int c, bit ovr,
                              logic [DW-1:0] hd, bit hpe, bit hfe);
    vec_t v;
    v.done = done; v.d = d; v.pe = pe; v.fe = fe;
    v.rdy = rdy; v.clr = clr; v.c = c; v.ovr = ovr;
    v.hd = hd; v.hpe = hpe; v.hfe = hfe;
    tbl.push_back(v);
  endfunction

  task automatic pulse(logic [DW-1:0] d);
    rx_data = d;
    rx_done = 1'b1;
    step();
    rx_done = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; rx_done = 1'b1; rx_data = '0;
    rx_parity_err = 0; rx_frame_err = 0;
    cpu_ready = 0; overrun_clr = 0;
    model_reset();
    step();
    step();
    rst = 1'b0;

    // Reset release with rx_done high, then single frame and pop
    add(1, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0);
    add(0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0);
    add(1, 8'hA5, 0, 0, 0, 0, 1, 0, 8'hA5, 0, 0);
    add(1, 8'hA5, 0, 0, 1, 0, 0, 0, 8'h00, 0, 0);
    add(0, 8'hA5, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0);
    // Five frames into four slots: last one dropped
    for (int k = 1; k <= 5; k++) begin
      add(1, 8'(k), 0, 0, 0, 0, (k > 4) ? 4 : k, k == 5, 8'h01, 0, 0);
      add(0, 8'(k), 0, 0, 0, 0, (k > 4) ? 4 : k, k == 5, 8'h01, 0, 0);
    end
    for (int k = 1; k <= 4; k++)
      add(0, 8'h05, 0, 0, 1, 0, 4 - k, 1, 8'(k + 1), 0, 0);
    add(0, 8'h05, 0, 0, 0, 1, 0, 0, 8'h00, 0, 0);
    // Fill, then push and pop together on a full FIFO
    for (int k = 1; k <= 4; k++) begin
      add(1, 8'(k * 17), 0, 0, 0, 0, k, 0, 8'h11, 0, 0);
      add(0, 8'(k * 17), 0, 0, 0, 0, k, 0, 8'h11, 0, 0);
    end
    add(1, 8'h55, 0, 0, 1, 0, 4, 0, 8'h22, 0, 0);
    add(0, 8'h55, 0, 0, 0, 0, 4, 0, 8'h22, 0, 0);
    add(0, 8'h55, 0, 0, 1, 0, 3, 0, 8'h33, 0, 0);
    add(0, 8'h55, 0, 0, 1, 0, 2, 0, 8'h44, 0, 0);
    add(0, 8'h55, 0, 0, 1, 0, 1, 0, 8'h55, 0, 0);
    add(0, 8'h55, 0, 0, 1, 0, 0, 0, 8'h00, 0, 0);
    // rx_done held high for ten cycles: one entry with parity flag
    for (int k = 0; k < 10; k++)
      add(1, 8'h3C, 1, 0, 0, 0, 1, 0, 8'h3C, 1, 0);
    add(0, 8'h3C, 1, 0, 0, 0, 1, 0, 8'h3C, 1, 0);
    add(0, 8'h3C, 0, 0, 1, 0, 0, 0, 8'h00, 0, 0);

    foreach (tbl[i]) begin
      rx_done       = tbl[i].done;
      rx_data       = tbl[i].d;
      rx_parity_err = tbl[i].pe;
      rx_frame_err  = tbl[i].fe;
      cpu_ready     = tbl[i].rdy;
      overrun_clr   = tbl[i].clr;
      step();
      cpu_ready   = 1'b0;
      overrun_clr = 1'b0;
      repeat (LAT - 1) step();
      chk("tbl_count", 32'(count), 32'(tbl[i].c));
      chk("tbl_valid", 32'(cpu_valid), 32'(tbl[i].c != 0));
      chk("tbl_overrun", 32'(overrun), 32'(tbl[i].ovr));
      if (tbl[i].c != 0)
        chk("tbl_head", 32'({cpu_data, cpu_parity_err, cpu_frame_err}),
            32'({tbl[i].hd, tbl[i].hpe, tbl[i].hfe}));
    end
    rx_parity_err = 0;

    // Overrun set and clear in the same cycle: set wins
    for (int k = 0; k < DEPTH; k++) pulse(8'(8'h61 + k));
    repeat (LAT) step();
    chk("fill_count", 32'(count), 32'(DEPTH));
    rx_data = 8'h70; rx_done = 1'b1; overrun_clr = 1'b1;
    repeat (LAT) step();
    chk("set_wins", 32'(overrun), 32'd1);
    rx_done = 1'b0;
    step();
    overrun_clr = 1'b0;
    chk("clr_ovr", 32'(overrun), 32'd0);
    chk("head_61", 32'(cpu_data), 32'h61);
    cpu_ready = 1'b1;
    repeat (DEPTH + LAT) step();
    cpu_ready = 1'b0;
    chk("drained", 32'(count), 32'd0);

    // Latency from rx_done rise to cpu_valid
    step();
    rx_data = 8'h99; rx_done = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!cpu_valid && n < 10);
    chk("latency", 32'(n), 32'(LAT));
    chk("lat_data", 32'(cpu_data), 32'h99);
    rx_done = 1'b0;
    cpu_ready = 1'b1;
    step();
    cpu_ready = 1'b0;

    // Ten push/pop pairs: pointers wrap, order preserved
    for (int k = 0; k < 10; k++) begin
      pulse(8'(8'hB0 + k));
      repeat (LAT) step();
      chk("wrap_head", 32'(cpu_data), 32'(8'hB0 + k));
      cpu_ready = 1'b1;
      step();
      cpu_ready = 1'b0;
    end

    // Reset mid-operation with rx_done high through release
    pulse(8'hC1);
    pulse(8'hC2);
    repeat (LAT) step();
    rx_done = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_count", 32'(count), 32'd0);
    repeat (LAT + 2) step();
    chk("rst_nopush", 32'(count), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 2) == 0) rx_done = ~rx_done;
      if (!rx_done) begin
        rx_data       = 8'($urandom);
        rx_parity_err = 1'($urandom);
        rx_frame_err  = 1'($urandom);
      end
      cpu_ready   = (i < 400) ? ($urandom_range(0, 3) == 0)
                              : ($urandom_range(0, 3) != 0);
      overrun_clr = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
